// File: rtl/ps2_key_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants and state encodings for the PS/2 keyboard
//            receiver: protocol scancodes, the game's key set, the rx and
//            output state machine encodings and a frame check helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Protocol prefix codes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Make codes the game reacts to
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_L     = 8'h4B;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_GAP  = 2'd2
  } out_state_t;

  // Odd parity over data+parity and a high stop bit
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return stop & (^{data, parity});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_if
// Purpose  : Scancode interface between the PS/2 receiver (master, producer)
//            and the game FSM (slave, consumer).
// Signals  : tasta[7:0] - last reported make code
//            done       - high while tasta holds a newly reported key
//            frame_err  - one-cycle pulse on a rejected frame
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_if;
  logic [7:0] tasta;
  logic       done;
  logic       frame_err;

  modport master (output tasta, output done, output frame_err);
  modport slave  (input  tasta, input  done, input  frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_key_receiver_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Synchronises the raw PS/2 clock and data lines, deglitches the
//            clock with a FILTER_LEN-deep agreement filter and flags each
//            falling edge of the filtered clock as a sample event.
// Ports    : clock, reset         - system clock, sync active-high reset
//            ps2_clk, ps2_data    - raw asynchronous connector lines
//            sample_evt           - one-cycle strobe on a filtered clk fall
//            sample_data          - synchronised data valid with sample_evt
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample_evt,
  output logic sample_data
);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt;

  // Idle PS/2 lines are high, so everything resets to 1 to avoid a false
  // edge coming out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= '1;
      clk_filt  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&clk_hist)
        clk_filt <= 1'b1;
      else if (~|clk_hist)
        clk_filt <= 1'b0;
    end
  end

  // The fall is flagged the cycle the history becomes all-zero, one cycle
  // ahead of clk_filt itself dropping.
  assign sample_evt  = clk_filt & ~(|clk_hist);
  assign sample_data = data_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_receiver
// Purpose  : PS/2 keyboard receiver. Deserialises 11-bit frames, checks odd
//            parity and stop bit, drops break sequences and E0 prefixes, and
//            reports each make code as a DONE_HOLD-cycle done pulse followed
//            by a DONE_HOLD-cycle quiet gap. One key arriving while busy is
//            buffered (latest wins).
// Ports    : clock, reset       - system clock, sync active-high reset
//            ps2_clk, ps2_data  - raw asynchronous PS/2 lines
//            key (master)       - tasta / done / frame_err
// Options  : PS2_TIMEOUT_EN - abandon a frame after TIMEOUT_CYCLES without a
//            sample event and pulse frame_err.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int DONE_HOLD      = 65536,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  ps2_key_if.master key
);

  localparam int              HOLD_W    = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

  logic sample_evt, sample_data;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .sample_evt  (sample_evt),
    .sample_data (sample_data)
  );

  // ---------------------------------------------------------------- rx FSM
  rx_state_t  rx_state, rx_next;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic       timeout_hit;
  logic       stop_evt, frame_good, frame_bad;

  always_ff @(posedge clock) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (timeout_hit) begin
      rx_next = RX_IDLE;
    end else if (sample_evt) begin
      case (rx_state)
        RX_IDLE:   if (!sample_data) rx_next = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) rx_next = RX_PARITY;
        RX_PARITY: rx_next = RX_STOP;
        RX_STOP:   rx_next = RX_IDLE;
        default:   rx_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_evt   = sample_evt && (rx_state == RX_STOP);
    frame_good = stop_evt &&  frame_ok(shift_reg, parity_bit, sample_data);
    frame_bad  = (stop_evt && !frame_ok(shift_reg, parity_bit, sample_data)) || timeout_hit;
  end

  // Bits arrive LSB first: shift in at the top so bit 0 ends up at [0].
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
    end else if (sample_evt) begin
      case (rx_state)
        RX_IDLE:   bit_cnt <= 3'd0;
        RX_DATA: begin
          shift_reg <= {sample_data, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        RX_PARITY: parity_bit <= sample_data;
        default:   ;
      endcase
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (reset || sample_evt || rx_state == RX_IDLE)
      idle_cnt <= '0;
    else if (!timeout_hit)
      idle_cnt <= idle_cnt + TO_W'(1);
  end

  assign timeout_hit = (rx_state != RX_IDLE) && (idle_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  // No watchdog: a partial frame simply waits for more edges.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // ------------------------------------------------------ byte classification
  logic break_pending;
  logic key_evt;

  assign key_evt = frame_good && (shift_reg != SC_BREAK) && (shift_reg != SC_EXT)
                   && !break_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      break_pending <= 1'b0;
    end else if (frame_good) begin
      if (shift_reg == SC_BREAK)
        break_pending <= 1'b1;
      else if (shift_reg != SC_EXT)
        break_pending <= 1'b0;
    end
  end

  // ------------------------------------------------------------- output FSM
  out_state_t        out_state, out_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic [7:0]        tasta_q;
  logic [7:0]        pend_byte;
  logic              pend_valid;
  logic              frame_err_q;
  logic              done_w;
  logic              load_key;

  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clock) begin
    if (reset) out_state <= OUT_IDLE;
    else       out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      OUT_IDLE: if (key_evt) out_next = OUT_HIGH;
      OUT_HIGH: if (hold_done) out_next = OUT_GAP;
      OUT_GAP:  if (hold_done) out_next = (key_evt || pend_valid) ? OUT_HIGH : OUT_IDLE;
      default:  out_next = OUT_IDLE;
    endcase
  end

  always_comb begin
    done_w   = (out_state == OUT_HIGH);
    load_key = (out_next == OUT_HIGH) && (out_state != OUT_HIGH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt    <= '0;
      tasta_q     <= 8'h00;
      pend_byte   <= 8'h00;
      pend_valid  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;

      if (out_state != out_next)
        hold_cnt <= '0;
      else if (out_state != OUT_IDLE)
        hold_cnt <= hold_cnt + HOLD_W'(1);

      // A key arriving on the very cycle the gap expires is newer than the
      // buffered one, so it takes priority.
      if (load_key) begin
        tasta_q    <= key_evt ? shift_reg : pend_byte;
        pend_valid <= 1'b0;
      end else if (key_evt && out_state != OUT_IDLE) begin
        pend_byte  <= shift_reg;
        pend_valid <= 1'b1;
      end
    end
  end

  assign key.tasta     = tasta_q;
  assign key.done      = done_w;
  assign key.frame_err = frame_err_q;

endmodule
`default_nettype wire
